// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a write to FF46 copies LENGTH bytes from a 256-byte source page into OAM.
// Optional macro OAM_DMA_CPU_BLOCK_EN drives cpu_blocked; without it the port is tied low.
module oam_dma_engine #(
  parameter int LENGTH     = 160,
  parameter int ECHO_REMAP = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        cpu_sel,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_di,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        active,
  output logic        cpu_blocked
);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  localparam logic [8:0] LAST_IDX = 9'(LENGTH - 1);

  state_t     state, state_next;
  logic [7:0] src, src_next;
  logic [7:0] dma_reg, dma_reg_next;
  logic [8:0] idx, idx_next;
  logic       reg_wr;
  logic       capture;
  logic [7:0] src_remapped;

  assign cpu_sel  = (cpu_addr == 16'hFF46);
  assign reg_wr   = ce & cpu_wr & cpu_sel;
  assign cpu_do   = dma_reg;
  assign dma_rd   = (state == XFER);
  assign dma_addr = {src, idx[7:0]};
  assign active   = (state != IDLE) | oam_wr;

  // Echo RAM pages E0-FF mirror work RAM C0-DF.
  assign src_remapped = ((ECHO_REMAP != 0) && (cpu_di >= 8'hE0)) ? (cpu_di - 8'h20) : cpu_di;

  always_comb begin
    state_next   = state;
    src_next     = src;
    idx_next     = idx;
    dma_reg_next = dma_reg;
    capture      = 1'b0;
    if (reg_wr) begin
      dma_reg_next = cpu_di;
      src_next     = src_remapped;
      idx_next     = 9'd0;
      state_next   = START;
    end else if (ce) begin
      case (state)
        START: state_next = XFER;
        XFER: begin
          capture  = 1'b1;
          idx_next = idx + 9'd1;
          if (idx == LAST_IDX) state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      src     <= 8'h00;
      idx     <= 9'd0;
      dma_reg <= 8'h00;
    end else begin
      state   <= state_next;
      src     <= src_next;
      idx     <= idx_next;
      dma_reg <= dma_reg_next;
    end
  end

  // A restart suppresses capture, so an in-flight oam_wr drops after its M-cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      oam_wr   <= 1'b0;
      oam_addr <= 8'h00;
      oam_data <= 8'h00;
    end else if (ce) begin
      oam_wr <= capture;
      if (capture) begin
        oam_addr <= idx[7:0];
        oam_data <= dma_di;
      end
    end
  end

`ifdef OAM_DMA_CPU_BLOCK_EN
  // HRAM stays reachable; the setup cycle leaves the bus free.
  assign cpu_blocked = active & (state != START) &
                       ~((cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE));
`else
  assign cpu_blocked = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine; a second instance covers ECHO_REMAP=0.
module tb_oam_dma_engine;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ce       = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr   = 1'b0;
  logic [7:0]  cpu_di   = 8'h00;

  logic [7:0]  cpu_do, oam_addr, oam_data, dma_di;
  logic        cpu_sel, dma_rd, oam_wr, active, cpu_blocked;
  logic [15:0] dma_addr;

  logic [7:0]  nr_cpu_do, nr_oam_addr, nr_oam_data, nr_dma_di;
  logic        nr_cpu_sel, nr_dma_rd, nr_oam_wr, nr_active, nr_cpu_blocked;
  logic [15:0] nr_dma_addr;

`ifdef OAM_DMA_CPU_BLOCK_EN
  localparam logic BLOCK_EN = 1'b1;
`else
  localparam logic BLOCK_EN = 1'b0;
`endif

  int          passed = 0;
  int          total  = 0;
  int          n_wr, n_bad, n_act, wr_seen;
  logic [15:0] last_rd, snap_addr;
  logic [7:0]  snap_oam_addr;
  logic        snap_oam_wr;

  always #5 clk_sys = ~clk_sys;

  // Source memory model: each byte holds the low byte of its own address.
  assign dma_di    = dma_addr[7:0];
  assign nr_dma_di = nr_dma_addr[7:0];

  oam_dma_engine #(.LENGTH(160), .ECHO_REMAP(1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_sel(cpu_sel),
    .dma_rd(dma_rd), .dma_addr(dma_addr), .dma_di(dma_di), .oam_wr(oam_wr),
    .oam_addr(oam_addr), .oam_data(oam_data), .active(active),
    .cpu_blocked(cpu_blocked)
  );

  oam_dma_engine #(.LENGTH(160), .ECHO_REMAP(0)) dut_noremap (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(nr_cpu_do), .cpu_sel(nr_cpu_sel),
    .dma_rd(nr_dma_rd), .dma_addr(nr_dma_addr), .dma_di(nr_dma_di), .oam_wr(nr_oam_wr),
    .oam_addr(nr_oam_addr), .oam_data(nr_oam_data), .active(nr_active),
    .cpu_blocked(nr_cpu_blocked)
  );

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Writes the DMA register; returns at the sample just after the write edge.
  task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] data);
    cpu_addr = addr;
    cpu_di   = data;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  // Follows a transfer from its current sample until active falls, scoring every read and write.
  task automatic follow_transfer(input logic [7:0] page, input int start_n,
                                 output int nw, output int nb, output int na,
                                 output logic [15:0] lr);
    nw = start_n;
    nb = 0;
    na = active ? 1 : 0;
    lr = 16'h0000;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (oam_wr) begin
        if (oam_addr !== 8'(nw) || oam_data !== 8'(nw)) nb++;
        nw++;
      end
      if (dma_rd) begin
        if (dma_addr !== {page, 8'(nw)}) nb++;
        lr = dma_addr;
      end
      if (!active) break;
      na++;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 400 && (active || nr_active); t++) tick();
    check_output(tag, {30'd0, active, nr_active}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting oam_dma_engine bench, BLOCK_EN=%0d", BLOCK_EN);
    ce = 1'b1;
    tick();
    check_output("reset_active", active, 0);
    check_output("reset_oam_wr", oam_wr, 0);
    check_output("reset_dma_rd", dma_rd, 0);
    check_output("reset_cpu_do", cpu_do, 8'h00);
    check_output("reset_oam_addr", oam_addr, 8'h00);
    check_output("reset_cpu_blocked", cpu_blocked, 0);
    reset_n = 1'b1;
    tick();

    cpu_addr = 16'hFF46; #1;
    check_output("sel_ff46", cpu_sel, 1);
    cpu_addr = 16'hFF1A; #1;
    check_output("sel_ff1a", cpu_sel, 0);
    apply_stimulus(16'hFF1A, 8'h55);
    tick();
    check_output("ignored_wr_active", active, 0);
    check_output("ignored_wr_cpu_do", cpu_do, 8'h00);

    // Basic copy from page C1.
    apply_stimulus(16'hFF46, 8'hC1);
    check_output("basic_start_active", active, 1);
    check_output("basic_start_rd", dma_rd, 0);
    check_output("basic_cpu_do", cpu_do, 8'hC1);
    follow_transfer(8'hC1, 0, n_wr, n_bad, n_act, last_rd);
    check_output("basic_wr_count", n_wr, 160);
    check_output("basic_bad", n_bad, 0);
    check_output("basic_active_ticks", n_act, 162);
    check_output("basic_last_rd", last_rd, 16'hC19F);
    check_output("basic_last_oam_addr", oam_addr, 8'h9F);
    check_output("basic_idle", active, 0);
    wait_idle("basic_timeout");

    // Echo remap on the main instance, none on the second.
    apply_stimulus(16'hFF46, 8'hE3);
    check_output("echo_cpu_do", cpu_do, 8'hE3);
    check_output("noremap_cpu_do", nr_cpu_do, 8'hE3);
    tick();
    check_output("echo_dma_addr", dma_addr, 16'hC300);
    check_output("noremap_dma_addr", nr_dma_addr, 16'hE300);
    wait_idle("echo_timeout");

    // Restart at byte 50.
    apply_stimulus(16'hFF46, 8'hC0);
    repeat (51) tick();
    check_output("restart_pre_wr", oam_wr, 1);
    check_output("restart_pre_oam_addr", oam_addr, 8'h31);
    check_output("restart_pre_oam_data", oam_data, 8'h31);
    check_output("restart_pre_dma_addr", dma_addr, 16'hC032);
    apply_stimulus(16'hFF46, 8'hD0);
    check_output("restart_wr_cleared", oam_wr, 0);
    check_output("restart_active", active, 1);
    check_output("restart_start_rd", dma_rd, 0);
    follow_transfer(8'hD0, 0, n_wr, n_bad, n_act, last_rd);
    check_output("restart_wr_count", n_wr, 160);
    check_output("restart_bad", n_bad, 0);
    check_output("restart_active_ticks", n_act, 162);
    check_output("restart_last_rd", last_rd, 16'hD09F);
    wait_idle("restart_timeout");

    // ce freeze mid-transfer.
    apply_stimulus(16'hFF46, 8'hC2);
    repeat (21) tick();
    snap_addr     = dma_addr;
    snap_oam_wr   = oam_wr;
    snap_oam_addr = oam_addr;
    check_output("freeze_pre_addr", snap_addr, 16'hC214);
    ce = 1'b0;
    repeat (10) tick();
    check_output("freeze_dma_addr", dma_addr, 16'hC214);
    check_output("freeze_oam_wr", oam_wr, 1);
    check_output("freeze_oam_addr", oam_addr, 8'h13);
    ce = 1'b1;
    follow_transfer(8'hC2, 20, n_wr, n_bad, n_act, last_rd);
    check_output("freeze_wr_count", n_wr, 160);
    check_output("freeze_bad", n_bad, 0);
    wait_idle("freeze_timeout");

    // Page DF is below the echo window; cpu_blocked behaviour.
    apply_stimulus(16'hFF46, 8'hDF);
    cpu_addr = 16'hC000; #1;
    check_output("blk_start", cpu_blocked, 0);
    tick();
    check_output("blk_df_no_remap", dma_addr, 16'hDF00);
    cpu_addr = 16'hC000; #1;
    check_output("blk_c000", cpu_blocked, BLOCK_EN);
    cpu_addr = 16'hFF90; #1;
    check_output("blk_ff90", cpu_blocked, 0);
    cpu_addr = 16'hFF80; #1;
    check_output("blk_ff80", cpu_blocked, 0);
    cpu_addr = 16'hFFFE; #1;
    check_output("blk_fffe", cpu_blocked, 0);
    cpu_addr = 16'hFFFF; #1;
    check_output("blk_ffff", cpu_blocked, BLOCK_EN);
    cpu_addr = 16'h0000;
    wait_idle("blk_timeout");
    cpu_addr = 16'hC000; #1;
    check_output("blk_idle", cpu_blocked, 0);
    cpu_addr = 16'h0000;

    // Async reset between edges.
    apply_stimulus(16'hFF46, 8'hC3);
    repeat (30) tick();
    #2 reset_n = 1'b0;
    #1;
    check_output("areset_active", active, 0);
    check_output("areset_oam_wr", oam_wr, 0);
    check_output("areset_dma_rd", dma_rd, 0);
    check_output("areset_cpu_do", cpu_do, 8'h00);
    tick();
    reset_n = 1'b1;
    wr_seen = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (oam_wr) wr_seen++;
    end
    check_output("post_reset_no_wr", wr_seen, 0);
    check_output("post_reset_active", active, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
